// File: rtl/ext_mem_responder.sv
// Two-channel byte-lane memory responder for the accelerator master port.
// It has programmable read/write latency, per-channel DataRdy, and a host init/readback port.
module ext_mem_responder #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MEMSIZE     = 32,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Mout_oe_ram,
  input  logic [1:0]          Mout_we_ram,
  input  logic [2*ADDR_W-1:0] Mout_addr_ram,
  input  logic [15:0]         Mout_Wdata_ram,
  input  logic [7:0]          Mout_data_ram_size,
  input  logic [15:0]         Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic [15:0]         M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
  input  logic                init_we,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic [7:0]          init_wdata,
  output logic [7:0]          init_rdata,
  output logic                err_collision
);

  localparam int unsigned IDX_W   = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int unsigned PD      = READ_DELAY - 1;
  localparam logic [2:0]  RD_LAST = 3'(READ_DELAY - 1);
  localparam logic [2:0]  WD_LAST = 3'(WRITE_DELAY - 1);

  logic [7:0]       mem  [MEMSIZE];
  logic [2:0]       cnt  [2];
  logic [2:0]       cnt_nxt [2];
  logic [7:0]       pipe [2][PD];
  logic [31:0]      addr_ext [2];
  logic [IDX_W-1:0] off [2];
  logic [7:0]       mask [2];
  logic [7:0]       merged [2];
  logic [7:0]       rd_byte [2];
  logic [1:0]       in_range;
  logic [1:0]       wr_en;
  logic             init_hit;

  assign init_hit = (32'(init_addr) < MEMSIZE);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    M_Rdata_ram = Sout_Rdata_ram;
    M_DataRdy   = Sout_DataRdy;
    for (int k = 0; k < 2; k++) begin
      addr_ext[k] = 32'(Mout_addr_ram[k*ADDR_W +: ADDR_W]);
      // Unsigned wrap makes addresses below BASE_ADDR fail the single compare.
      in_range[k] = ((addr_ext[k] - BASE_ADDR) < MEMSIZE);
      off[k]      = IDX_W'(addr_ext[k] - BASE_ADDR);
      mask[k]     = (Mout_data_ram_size[4*k +: 4] >= 4'd8) ? 8'hFF
                  : 8'((16'd1 << Mout_data_ram_size[4*k +: 4]) - 16'd1);
      merged[k]   = (Mout_Wdata_ram[8*k +: 8] & mask[k]) | (mem[off[k]] & ~mask[k]);
      rd_byte[k]  = (Mout_oe_ram[k] && in_range[k]) ? mem[off[k]] : 8'h00;
      wr_en[k]    = Mout_we_ram[k] && !Mout_oe_ram[k] && in_range[k];

      cnt_nxt[k] = 3'd0;
      if ((Mout_oe_ram[k] ^ Mout_we_ram[k]) && in_range[k]) begin
        if (cnt[k] < (Mout_oe_ram[k] ? RD_LAST : WD_LAST)) cnt_nxt[k] = cnt[k] + 3'd1;
      end

      M_DataRdy[k] = Sout_DataRdy[k] |
                     (in_range[k] && ((cnt[k] == RD_LAST) ||
                                      (Mout_we_ram[k] && (cnt[k] == WD_LAST))));
      M_Rdata_ram[8*k +: 8] = pipe[k][PD-1] | Sout_Rdata_ram[8*k +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_collision <= 1'b0;
      init_rdata    <= 8'h00;
      for (int k = 0; k < 2; k++) begin
        cnt[k] <= 3'd0;
        for (int s = 0; s < PD; s++) pipe[k][s] <= 8'h00;
      end
    end else begin
      if (|(Mout_oe_ram & Mout_we_ram)) err_collision <= 1'b1;
      init_rdata <= init_hit ? mem[init_addr[IDX_W-1:0]] : 8'h00;
      for (int k = 0; k < 2; k++) begin
        cnt[k] <= cnt_nxt[k];
        for (int s = PD - 1; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
        pipe[k][0] <= rd_byte[k];
      end
    end
  end

  // NOTE: the byte array is deliberately not reset so loaded contents survive a reset.
  // Later assignments win: host, then channel 0, then channel 1.
  always_ff @(posedge clock) begin
    if (init_we && init_hit) mem[init_addr[IDX_W-1:0]] <= init_wdata;
    if (wr_en[0]) mem[off[0]] <= merged[0];
    if (wr_en[1]) mem[off[1]] <= merged[1];
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed self-checking bench for ext_mem_responder (default instance plus a READ_DELAY=4 instance).
module tb_ext_mem_responder;

  logic        clock;
  logic        reset;
  logic [1:0]  oe, we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [7:0]  size;
  logic [15:0] s_rdata;
  logic [1:0]  s_rdy;
  logic        init_we;
  logic [6:0]  init_addr;
  logic [7:0]  init_wdata;

  logic [15:0] rdata, rdata4;
  logic [1:0]  rdy, rdy4;
  logic [7:0]  init_rdata, init_rdata4;
  logic        err, err4;

  int checks;
  int failures;

  ext_mem_responder dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .Sout_Rdata_ram(s_rdata), .Sout_DataRdy(s_rdy),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
    .init_rdata(init_rdata), .err_collision(err)
  );

  ext_mem_responder #(.READ_DELAY(4)) dut_rd4 (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .Sout_Rdata_ram(s_rdata), .Sout_DataRdy(s_rdy),
    .M_Rdata_ram(rdata4), .M_DataRdy(rdy4),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
    .init_rdata(init_rdata4), .err_collision(err4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_bus();
    oe = 2'b00; we = 2'b00; addr = '0; wdata = '0; size = '0;
    s_rdata = '0; s_rdy = '0; init_we = 1'b0; init_wdata = '0;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_wdata = d;
    tick();
    init_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear_bus(); init_addr = '0;
    tick();
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 16'h0000); end
    checks++; if (rdy !== 2'b00) begin failures++; $display("FAIL reset_rdy got=%b exp=%b", rdy, 2'b00); end
    checks++; if (init_rdata !== 8'h00) begin failures++; $display("FAIL reset_init_rdata got=%h exp=%h", init_rdata, 8'h00); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=%b", err, 1'b0); end
    s_rdata = 16'h1234; s_rdy = 2'b10;
    #1;
    checks++; if (rdata !== 16'h1234) begin failures++; $display("FAIL reset_sout_rdata got=%h exp=%h", rdata, 16'h1234); end
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL reset_sout_rdy got=%b exp=%b", rdy, 2'b10); end
    s_rdata = '0; s_rdy = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read();
    host_write(7'd0, 8'h11); host_write(7'd1, 8'h22);
    host_write(7'd2, 8'h33); host_write(7'd3, 8'h44);
    oe = 2'b01; addr[6:0] = 7'd2;
    #1;
    checks++; if (rdy !== 2'b00) begin failures++; $display("FAIL read_rdy_c0 got=%b exp=%b", rdy, 2'b00); end
    tick();
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL read_rdy_c1 got=%b exp=%b", rdy, 2'b01); end
    checks++; if (rdata[7:0] !== 8'h33) begin failures++; $display("FAIL read_data got=%h exp=%h", rdata[7:0], 8'h33); end
    oe = 2'b00;
    tick();
    checks++; if (rdy !== 2'b00) begin failures++; $display("FAIL read_rdy_c2 got=%b exp=%b", rdy, 2'b00); end
  endtask

  task automatic test_write();
    we = 2'b10; addr[13:7] = 7'd5; wdata[15:8] = 8'hA5; size[7:4] = 4'd8;
    #1;
    checks++; if (rdy[1] !== 1'b1) begin failures++; $display("FAIL write_rdy got=%b exp=%b", rdy[1], 1'b1); end
    tick();
    we = 2'b00; oe = 2'b10;
    #1;
    checks++; if (rdy[1] !== 1'b0) begin failures++; $display("FAIL write_rd_rdy_c0 got=%b exp=%b", rdy[1], 1'b0); end
    tick();
    checks++; if (rdy[1] !== 1'b1) begin failures++; $display("FAIL write_rd_rdy_c1 got=%b exp=%b", rdy[1], 1'b1); end
    checks++; if (rdata[15:8] !== 8'hA5) begin failures++; $display("FAIL write_rd_data got=%h exp=%h", rdata[15:8], 8'hA5); end
    oe = 2'b00; init_addr = 7'd5;
    tick();
    checks++; if (init_rdata !== 8'hA5) begin failures++; $display("FAIL write_init_rdata got=%h exp=%h", init_rdata, 8'hA5); end
    clear_bus();
  endtask

  task automatic test_mask();
    host_write(7'd7, 8'hFF);
    we = 2'b01; addr[6:0] = 7'd7; wdata[7:0] = 8'h00; size[3:0] = 4'd4; init_addr = 7'd7;
    tick();
    we = 2'b00;
    tick();
    checks++; if (init_rdata !== 8'hF0) begin failures++; $display("FAIL mask_size4 got=%h exp=%h", init_rdata, 8'hF0); end
    we = 2'b01; size[3:0] = 4'd0;
    tick();
    we = 2'b00;
    tick();
    checks++; if (init_rdata !== 8'hF0) begin failures++; $display("FAIL mask_size0 got=%h exp=%h", init_rdata, 8'hF0); end
    clear_bus();
  endtask

  task automatic test_out_of_range();
    oe = 2'b01; addr[6:0] = 7'd40; addr[13:7] = 7'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL oor_rdy cyc=%0d got=%b exp=%b", i, rdy[0], 1'b0); end
      checks++; if (rdata[7:0] !== 8'h00) begin failures++; $display("FAIL oor_data cyc=%0d got=%h exp=%h", i, rdata[7:0], 8'h00); end
      tick();
    end
    s_rdata = 16'h005A; s_rdy = 2'b01;
    #1;
    checks++; if (rdata !== 16'h005A) begin failures++; $display("FAIL oor_sout_rdata got=%h exp=%h", rdata, 16'h005A); end
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL oor_sout_rdy got=%b exp=%b", rdy, 2'b01); end
    clear_bus();
    tick();
  endtask

  task automatic test_collision();
    init_addr = 7'd1;
    oe = 2'b01; we = 2'b01; addr[6:0] = 7'd1; wdata[7:0] = 8'hFF; size[3:0] = 4'd8;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL coll_err_before got=%b exp=%b", err, 1'b0); end
    tick();
    clear_bus();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL coll_err_set got=%b exp=%b", err, 1'b1); end
    tick();
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL coll_err_sticky got=%b exp=%b", err, 1'b1); end
    checks++; if (init_rdata !== 8'h22) begin failures++; $display("FAIL coll_mem got=%h exp=%h", init_rdata, 8'h22); end
    reset = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL coll_err_reset got=%b exp=%b", err, 1'b0); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_dual_write();
    we = 2'b11; addr = {7'd3, 7'd3}; wdata = 16'h2211; size = 8'h88;
    tick();
    clear_bus(); init_addr = 7'd3;
    tick();
    checks++; if (init_rdata !== 8'h22) begin failures++; $display("FAIL dual_write got=%h exp=%h", init_rdata, 8'h22); end
  endtask

  task automatic test_back_to_back();
    oe = 2'b01; addr[6:0] = 7'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (rdy[0] !== ((i % 2) == 1)) begin failures++; $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", i, rdy[0], ((i % 2) == 1)); end
      if ((i % 2) == 1) begin
        checks++; if (rdata[7:0] !== 8'h33) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, rdata[7:0], 8'h33); end
      end
      tick();
    end
    clear_bus();
    tick();
  endtask

  task automatic test_reset_midread();
    oe = 2'b01; addr[6:0] = 7'd2;
    #1;
    checks++; if (rdy4[0] !== 1'b0) begin failures++; $display("FAIL rd4_rdy_c0 got=%b exp=%b", rdy4[0], 1'b0); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (rdy4[0] !== 1'b0) begin failures++; $display("FAIL rd4_rdy_in_reset got=%b exp=%b", rdy4[0], 1'b0); end
    tick();
    checks++; if (rdy4[0] !== 1'b0) begin failures++; $display("FAIL rd4_rdy_in_reset2 got=%b exp=%b", rdy4[0], 1'b0); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rdy4[0] !== (i == 3)) begin failures++; $display("FAIL rd4_after_release cyc=%0d got=%b exp=%b", i, rdy4[0], (i == 3)); end
      tick();
    end
    clear_bus();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_mask();
    test_out_of_range();
    test_collision();
    test_dual_write();
    test_back_to_back();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
